// File: rtl/stack_alu_pkg.sv
// Shared types for the stack ALU sequencer: data width default, command and response encodings, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stack_alu_pkg;

    // Default data / opcode width used by the sequencer and its operand store.
    localparam int DATA_W = 16;

    // Command kinds carried on cmd_kind.
    typedef enum logic [1:0] {
        KIND_PUSH  = 2'd0,
        KIND_OP    = 2'd1,
        KIND_POP   = 2'd2,
        KIND_CLEAR = 2'd3
    } cmd_kind_t;

    // Completion codes carried on rsp_code.
    typedef enum logic [2:0] {
        RSP_OK        = 3'd0,
        RSP_UNDERFLOW = 3'd1,
        RSP_OVERFLOW  = 3'd2,
        RSP_ALU_ERR   = 3'd3,
        RSP_TIMEOUT   = 3'd4
    } rsp_code_t;

    // Sequencer states: accept, start ALU, wait for ALU, emit response.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/op_stack.sv
// Operand stack: DEPTH x W storage with top/second read ports, push, pop, replace-top and clear.
// Latency: reads are combinational from registered state; updates take effect at the next rising edge.
// Backpressure: none; push when full and pop when empty are ignored so the pointer never wraps.
module op_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         repl_i,
    input  logic                         clr_i,
    input  logic [W-1:0]                 wdat_i,
    output logic [W-1:0]                 top_o,
    output logic [W-1:0]                 second_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign depth_o  = depth_q;
    assign top_o    = empty ? '0 : mem_q[IW'(depth_q - DW'(1))];
    assign second_o = (depth_q >= DW'(2)) ? mem_q[IW'(depth_q - DW'(2))] : '0;

    // Write slot select: push lands above the top; pop+replace folds two operands into one slot.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (clr_i) begin
            wr_en = 1'b0;
        end else if (push_i && !full) begin
            wr_en  = 1'b1;
            wr_idx = IW'(depth_q);
        end else if (repl_i && pop_i && (depth_q >= DW'(2))) begin
            wr_en  = 1'b1;
            wr_idx = IW'(depth_q - DW'(2));
        end else if (repl_i && !pop_i && !empty) begin
            wr_en  = 1'b1;
            wr_idx = IW'(depth_q - DW'(1));
        end
    end

    // Storage array; contents are left unreset since depth alone defines validity.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wdat_i;
        end
    end

    // Occupancy pointer, saturating at both ends.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            depth_q <= '0;
        end else if (clr_i) begin
            depth_q <= '0;
        end else if (push_i && !full) begin
            depth_q <= depth_q + DW'(1);
        end else if (pop_i && !empty) begin
            depth_q <= depth_q - DW'(1);
        end
    end

endmodule

// File: rtl/stack_alu_seq.sv
// Stack ALU sequencer: PUSH/POP/CLEAR/OP commands against an operand stack, OPs offloaded to an external ALU.
// Latency: single-cycle commands respond in N+1; OP issues go in N+1 and responds the cycle after done (or timeout).
// Backpressure: cmd_ready is high only in IDLE; one command in flight, exactly one rsp_valid pulse per accepted command.
module stack_alu_seq
    import stack_alu_pkg::*;
#(
    parameter int W       = DATA_W,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_kind,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    output logic [2:0]   rsp_code,
    output logic [W-1:0] rsp_data,
    output logic [3:0]   depth,
    output logic         err_sticky,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [W-1:0] alu_op,
    output logic         go,
    input  logic [W-1:0] alu_out,
    input  logic         done,
    input  logic         err_flag
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic          go_q;
    logic          rsp_valid_q;
    rsp_code_t     rsp_code_q;
    logic [W-1:0]  rsp_data_q;
    logic          err_sticky_q;
    logic [W-1:0]  alu_a_q;
    logic [W-1:0]  alu_b_q;
    logic [W-1:0]  alu_op_q;
    logic [CW-1:0] wcnt_q;

    logic          cmd_accept;
    logic          alu_ok;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_repl;
    logic          stk_clr;
    logic [W-1:0]  stk_wdat;
    logic [W-1:0]  stk_top;
    logic [W-1:0]  stk_second;
    logic [DW-1:0] stk_depth;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_two;

    assign stk_full  = (stk_depth == DW'(DEPTH));
    assign stk_empty = (stk_depth == '0);
    assign stk_two   = (stk_depth >= DW'(2));

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_code   = rsp_code_q;
    assign rsp_data   = rsp_data_q;
    assign depth      = 4'(stk_depth);
    assign err_sticky = err_sticky_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign go         = go_q;

    // Decode what this cycle does to the operand store (accepted command or successful ALU completion).
    always_comb begin
        cmd_accept = cmd_valid && (state_q == ST_IDLE);
        alu_ok     = (state_q == ST_WAIT) && done && !err_flag;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_repl   = 1'b0;
        stk_clr    = 1'b0;
        stk_wdat   = cmd_data;
        if (cmd_accept) begin
            case (cmd_kind_t'(cmd_kind))
                KIND_PUSH:  stk_push = !stk_full;
                KIND_POP:   stk_pop  = !stk_empty;
                KIND_CLEAR: stk_clr  = 1'b1;
                default:    stk_push = 1'b0;
            endcase
        end
        if (alu_ok) begin
            stk_pop  = 1'b1;
            stk_repl = 1'b1;
            stk_wdat = alu_out;
        end
    end

    op_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_op_stack (
        .clk_i    (clock),
        .rst_n_i  (reset_n),
        .push_i   (stk_push),
        .pop_i    (stk_pop),
        .repl_i   (stk_repl),
        .clr_i    (stk_clr),
        .wdat_i   (stk_wdat),
        .top_o    (stk_top),
        .second_o (stk_second),
        .depth_o  (stk_depth)
    );

    // Sequencer FSM with registered go / response / operand outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            go_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= RSP_OK;
            rsp_data_q   <= '0;
            err_sticky_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            wcnt_q       <= '0;
        end else begin
            go_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_code_q  <= RSP_OK;
                        rsp_data_q  <= '0;
                        case (cmd_kind_t'(cmd_kind))
                            KIND_PUSH: begin
                                if (stk_full) begin
                                    rsp_code_q   <= RSP_OVERFLOW;
                                    err_sticky_q <= 1'b1;
                                end else begin
                                    rsp_data_q <= cmd_data;
                                end
                            end
                            KIND_POP: begin
                                if (stk_empty) begin
                                    rsp_code_q   <= RSP_UNDERFLOW;
                                    err_sticky_q <= 1'b1;
                                end else begin
                                    rsp_data_q <= stk_top;
                                end
                            end
                            KIND_CLEAR: begin
                                err_sticky_q <= 1'b0;
                            end
                            KIND_OP: begin
                                if (!stk_two) begin
                                    rsp_code_q   <= RSP_UNDERFLOW;
                                    err_sticky_q <= 1'b1;
                                end else begin
                                    // Operands latched here and held until the ALU exchange ends.
                                    state_q     <= ST_ISSUE;
                                    rsp_valid_q <= 1'b0;
                                    go_q        <= 1'b1;
                                    alu_a_q     <= stk_second;
                                    alu_b_q     <= stk_top;
                                    alu_op_q    <= cmd_data;
                                end
                            end
                            default: begin
                                state_q <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    wcnt_q  <= '0;
                end
                ST_WAIT: begin
                    if (done) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        if (err_flag) begin
                            rsp_code_q   <= RSP_ALU_ERR;
                            rsp_data_q   <= '0;
                            err_sticky_q <= 1'b1;
                        end else begin
                            rsp_code_q <= RSP_OK;
                            rsp_data_q <= alu_out;
                        end
                    end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                        // TIMEOUT cycles spent in WAIT with no done: give up, stack untouched.
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_code_q   <= RSP_TIMEOUT;
                        rsp_data_q   <= '0;
                        err_sticky_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_q    <= ST_IDLE;
                    rsp_code_q <= RSP_OK;
                    rsp_data_q <= '0;
                    wcnt_q     <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
